// File: rtl/ar_trace_player.sv
// ar_trace_player
// Replays a timestamped GPU memory trace as AXI read-address traffic.
// Trace entries outside [cfg_bar, cfg_limit] are counted and dropped. Each
// remaining entry is held back by (GPU-cycle delta >> GPU_RATIO_SHIFT)
// enabled cycles and then issued as a single AR. Up to 2^LOG_MAX_OUTSTANDING
// ARs may be outstanding. Request-to-last-beat latency is accumulated from
// the R channel.
//
// Ports
//   clk, resetN           : clock, synchronous active-low reset
//   en                    : enable (freezes pacing and trace acceptance)
//   t_valid/t_ready       : trace entry handshake
//   t_cycle/t_addr/t_last : trace entry payload
//   cfg_bar/cfg_limit     : inclusive address window
//   cfg_id/cfg_len        : AR id and length
//   m_ar_*                : AXI read-address master channel
//   m_r_*                 : AXI read-data channel (ready is always high)
//   st_*                  : request/response/filter counts, latency sum/max
//   outstanding           : ARs issued but not yet completed
//   done                  : trace finished and all responses returned (sticky)
//   err                   : unexpected last beat or foreign R id (sticky)
module ar_trace_player #(
    parameter int ADDR_BITS           = 16,
    parameter int TID_WIDTH           = 8,
    parameter int BURST_LEN_WIDTH     = 8,
    parameter int CYCLE_WIDTH         = 32,
    parameter int GPU_RATIO_SHIFT     = 1,
    parameter int LOG_MAX_OUTSTANDING = 4,
    parameter int STAT_WIDTH          = 32
) (
    input  logic                           clk,
    input  logic                           resetN,
    input  logic                           en,
    input  logic                           t_valid,
    output logic                           t_ready,
    input  logic [CYCLE_WIDTH-1:0]         t_cycle,
    input  logic [ADDR_BITS-1:0]           t_addr,
    input  logic                           t_last,
    input  logic [ADDR_BITS-1:0]           cfg_bar,
    input  logic [ADDR_BITS-1:0]           cfg_limit,
    input  logic [TID_WIDTH-1:0]           cfg_id,
    input  logic [BURST_LEN_WIDTH-1:0]     cfg_len,
    output logic                           m_ar_valid,
    input  logic                           m_ar_ready,
    output logic [ADDR_BITS-1:0]           m_ar_addr,
    output logic [BURST_LEN_WIDTH-1:0]     m_ar_len,
    output logic [TID_WIDTH-1:0]           m_ar_id,
    input  logic                           m_r_valid,
    output logic                           m_r_ready,
    input  logic                           m_r_last,
    input  logic [TID_WIDTH-1:0]           m_r_id,
    output logic [STAT_WIDTH-1:0]          st_reqCount,
    output logic [STAT_WIDTH-1:0]          st_respCount,
    output logic [STAT_WIDTH-1:0]          st_filtCount,
    output logic [STAT_WIDTH-1:0]          st_latSum,
    output logic [STAT_WIDTH-1:0]          st_latMax,
    output logic [LOG_MAX_OUTSTANDING:0]   outstanding,
    output logic                           done,
    output logic                           err
);

    localparam int OW    = LOG_MAX_OUTSTANDING + 1;
    localparam int DEPTH = 1 << LOG_MAX_OUTSTANDING;
    localparam logic [OW-1:0] MAX_OUT = OW'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e                          state_q, state_d;
    logic                            init_q;
    logic [ADDR_BITS-1:0]            addr_q;
    logic                            last_q;
    logic [CYCLE_WIDTH-1:0]          prev_cycle_q;
    logic [CYCLE_WIDTH-1:0]          wait_q;
    logic [BURST_LEN_WIDTH-1:0]      len_q;
    logic [TID_WIDTH-1:0]            id_q;
    logic [STAT_WIDTH-1:0]           issue_ts_q;
    logic [STAT_WIDTH-1:0]           cyc_q;
    logic [STAT_WIDTH-1:0]           fifo_q [DEPTH];
    logic [LOG_MAX_OUTSTANDING-1:0]  wr_ptr_q, rd_ptr_q;
    logic [OW-1:0]                   out_q;
    logic [STAT_WIDTH-1:0]           req_q, resp_q, filt_q, lat_sum_q, lat_max_q;
    logic                            done_q, err_q;

    logic                            t_ready_s;
    logic                            ar_valid_s;
    logic                            accept_s;
    logic                            in_range_s;
    logic [CYCLE_WIDTH-1:0]          delta_s;
    logic [CYCLE_WIDTH-1:0]          wait_load_s;
    logic                            ar_hs_s;
    logic                            r_last_s;
    logic                            pop_s;
    logic                            room_s;
    logic                            wait_done_s;
    logic [STAT_WIDTH-1:0]           lat_s;

    assign accept_s    = t_valid & t_ready_s;
    assign in_range_s  = (t_addr >= cfg_bar) && (t_addr <= cfg_limit);
    assign delta_s     = t_cycle - prev_cycle_q;
    assign wait_load_s = delta_s >> GPU_RATIO_SHIFT;
    assign ar_hs_s     = ar_valid_s & m_ar_ready;
    assign r_last_s    = m_r_valid & m_r_last;
    assign pop_s       = r_last_s && (out_q != '0);
    // A completing response frees a slot this cycle, so a full window may
    // still release the next request without waiting for the count update.
    assign room_s      = (out_q < MAX_OUT) || pop_s;
    // The WAIT state itself spends one cycle, so leaving at a count of 1
    // (or 0 for a zero wait) puts the AR at accept + 1 + W.
    assign wait_done_s = en && (wait_q <= CYCLE_WIDTH'(1)) && room_s;
    assign lat_s       = cyc_q - fifo_q[rd_ptr_q];

    // FSM state register
    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    if (in_range_s) begin
                        state_d = S_WAIT;
                    end else if (t_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (wait_done_s) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_ISSUE: begin
                if (ar_hs_s) begin
                    state_d = last_q ? S_DRAIN : S_IDLE;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_DRAIN: state_d = S_DRAIN;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; trace acceptance is held off for one cycle after reset
    always_comb begin
        t_ready_s  = 1'b0;
        ar_valid_s = 1'b0;
        case (state_q)
            S_IDLE:  t_ready_s  = en & init_q;
            S_ISSUE: ar_valid_s = 1'b1;
            default: begin
                t_ready_s  = 1'b0;
                ar_valid_s = 1'b0;
            end
        endcase
    end

    // Entry capture, pacing counter and AR payload latch
    always_ff @(posedge clk) begin
        if (!resetN) begin
            init_q       <= 1'b0;
            cyc_q        <= '0;
            addr_q       <= '0;
            last_q       <= 1'b0;
            prev_cycle_q <= '0;
            wait_q       <= '0;
            len_q        <= '0;
            id_q         <= '0;
            issue_ts_q   <= '0;
        end else begin
            init_q <= 1'b1;
            cyc_q  <= cyc_q + STAT_WIDTH'(1);
            if (accept_s && in_range_s) begin
                addr_q       <= t_addr;
                last_q       <= t_last;
                prev_cycle_q <= t_cycle;
                wait_q       <= wait_load_s;
            end else if ((state_q == S_WAIT) && en && (wait_q != '0)) begin
                wait_q <= wait_q - CYCLE_WIDTH'(1);
            end
            // Timestamp is the counter value of the first m_ar_valid cycle
            if ((state_q == S_WAIT) && wait_done_s) begin
                len_q      <= cfg_len;
                id_q       <= cfg_id;
                issue_ts_q <= cyc_q + STAT_WIDTH'(1);
            end
        end
    end

    // Issue-timestamp FIFO storage
    always_ff @(posedge clk) begin
        if (ar_hs_s) begin
            fifo_q[wr_ptr_q] <= issue_ts_q;
        end
    end

    // FIFO pointers, outstanding count and statistics
    always_ff @(posedge clk) begin
        if (!resetN) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            out_q     <= '0;
            req_q     <= '0;
            resp_q    <= '0;
            filt_q    <= '0;
            lat_sum_q <= '0;
            lat_max_q <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            if (accept_s && !in_range_s) begin
                filt_q <= filt_q + STAT_WIDTH'(1);
            end
            if (ar_hs_s) begin
                wr_ptr_q <= wr_ptr_q + LOG_MAX_OUTSTANDING'(1);
                req_q    <= req_q + STAT_WIDTH'(1);
            end
            if (pop_s) begin
                rd_ptr_q  <= rd_ptr_q + LOG_MAX_OUTSTANDING'(1);
                resp_q    <= resp_q + STAT_WIDTH'(1);
                lat_sum_q <= lat_sum_q + lat_s;
                if (lat_s > lat_max_q) begin
                    lat_max_q <= lat_s;
                end
            end
            case ({ar_hs_s, pop_s})
                2'b10:   out_q <= out_q + OW'(1);
                2'b01:   out_q <= out_q - OW'(1);
                default: out_q <= out_q;
            endcase
            if ((r_last_s && (out_q == '0)) || (m_r_valid && (m_r_id != cfg_id))) begin
                err_q <= 1'b1;
            end
            if ((state_q == S_DRAIN) && (out_q == '0)) begin
                done_q <= 1'b1;
            end
        end
    end

    assign t_ready      = t_ready_s;
    assign m_ar_valid   = ar_valid_s;
    assign m_ar_addr    = addr_q;
    assign m_ar_len     = len_q;
    assign m_ar_id      = id_q;
    assign m_r_ready    = 1'b1;
    assign st_reqCount  = req_q;
    assign st_respCount = resp_q;
    assign st_filtCount = filt_q;
    assign st_latSum    = lat_sum_q;
    assign st_latMax    = lat_max_q;
    assign outstanding  = out_q;
    assign done         = done_q;
    assign err          = err_q;

endmodule

// File: tb/tb_ar_trace_player.sv
// Directed testbench for ar_trace_player (two outstanding ARs maximum).
module tb_ar_trace_player;

    logic        clk = 1'b0;
    logic        resetN, en, t_valid, t_ready, t_last;
    logic [31:0] t_cycle;
    logic [15:0] t_addr, cfg_bar, cfg_limit;
    logic [7:0]  cfg_id, cfg_len;
    logic        m_ar_valid, m_ar_ready;
    logic [15:0] m_ar_addr;
    logic [7:0]  m_ar_len, m_ar_id;
    logic        m_r_valid, m_r_ready, m_r_last;
    logic [7:0]  m_r_id;
    logic [31:0] st_reqCount, st_respCount, st_filtCount, st_latSum, st_latMax;
    logic [1:0]  outstanding;
    logic        done, err;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int a_c, c_c, d1, d2, d3, e_c, f_c;

    always #5 clk = ~clk;

    ar_trace_player #(.LOG_MAX_OUTSTANDING(1)) dut (
        .clk(clk), .resetN(resetN), .en(en),
        .t_valid(t_valid), .t_ready(t_ready), .t_cycle(t_cycle),
        .t_addr(t_addr), .t_last(t_last),
        .cfg_bar(cfg_bar), .cfg_limit(cfg_limit), .cfg_id(cfg_id), .cfg_len(cfg_len),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready), .m_ar_addr(m_ar_addr),
        .m_ar_len(m_ar_len), .m_ar_id(m_ar_id),
        .m_r_valid(m_r_valid), .m_r_ready(m_r_ready), .m_r_last(m_r_last), .m_r_id(m_r_id),
        .st_reqCount(st_reqCount), .st_respCount(st_respCount), .st_filtCount(st_filtCount),
        .st_latSum(st_latSum), .st_latMax(st_latMax),
        .outstanding(outstanding), .done(done), .err(err)
    );

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) tick();
    endtask

    // Present one entry, wait (bounded) for acceptance, record accept cycle
    task automatic send(input logic [31:0] c, input logic [15:0] a, input logic l);
        int n;
        t_cycle = c; t_addr = a; t_last = l; t_valid = 1'b1;
        n = 0;
        while (t_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        chk("accept_ready", 64'(t_ready), 64'(1'b1));
        acc_cyc = cyc;
        tick();
        t_valid = 1'b0;
        t_last  = 1'b0;
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        tick();
        tick();
        resetN = 1'b1;
        tick();
    endtask

    task automatic r_last_beat(input logic on);
        m_r_valid = on; m_r_last = on; m_r_id = cfg_id;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetN = 1'b0; en = 1'b1; t_valid = 1'b0; t_last = 1'b0;
        t_cycle = 32'd0; t_addr = 16'h0000;
        cfg_bar = 16'h0500; cfg_limit = 16'h4500; cfg_id = 8'h3C; cfg_len = 8'h07;
        m_ar_ready = 1'b1; m_r_valid = 1'b0; m_r_last = 1'b0; m_r_id = 8'h3C;

        // Reset state
        tick();
        tick();
        chk("rst_ar_valid", 64'(m_ar_valid), 64'(1'b0));
        chk("rst_outstanding", 64'(outstanding), 64'(2'd0));
        chk("rst_req", 64'(st_reqCount), 64'(32'd0));
        chk("rst_done", 64'(done), 64'(1'b0));
        chk("rst_err", 64'(err), 64'(1'b0));
        resetN = 1'b1;
        chk("rst_t_ready_first", 64'(t_ready), 64'(1'b0));
        tick();
        chk("rst_t_ready_after", 64'(t_ready), 64'(1'b1));

        // Basic pacing and 80-cycle latency: W=(10-0)>>1=5, AR at A+6
        send(32'd10, 16'h0540, 1'b0);
        a_c = acc_cyc;
        chk("t1_t_ready_wait", 64'(t_ready), 64'(1'b0));
        wait_until(a_c + 5);
        chk("t1_valid_early", 64'(m_ar_valid), 64'(1'b0));
        tick();
        chk("t1_valid", 64'(m_ar_valid), 64'(1'b1));
        chk("t1_addr", 64'(m_ar_addr), 64'(16'h0540));
        chk("t1_id", 64'(m_ar_id), 64'(8'h3C));
        chk("t1_len", 64'(m_ar_len), 64'(8'h07));
        tick();
        chk("t1_valid_drop", 64'(m_ar_valid), 64'(1'b0));
        chk("t1_outstanding", 64'(outstanding), 64'(2'd1));
        chk("t1_req", 64'(st_reqCount), 64'(32'd1));
        // A non-last beat does not complete the request
        wait_until(a_c + 50);
        m_r_valid = 1'b1; m_r_last = 1'b0; m_r_id = cfg_id;
        tick();
        r_last_beat(1'b0);
        chk("t1_nonlast_resp", 64'(st_respCount), 64'(32'd0));
        wait_until(a_c + 86);
        r_last_beat(1'b1);
        tick();
        r_last_beat(1'b0);
        chk("t1_latsum", 64'(st_latSum), 64'(32'd80));
        chk("t1_latmax", 64'(st_latMax), 64'(32'd80));
        chk("t1_resp", 64'(st_respCount), 64'(32'd1));
        chk("t1_outstanding0", 64'(outstanding), 64'(2'd0));
        chk("t1_err", 64'(err), 64'(1'b0));

        // Address window: two filtered entries, then limit-boundary entry at cycle 20 (W=10)
        do_reset();
        send(32'd12, 16'h0100, 1'b0);
        send(32'd14, 16'h4600, 1'b0);
        chk("t2_filt", 64'(st_filtCount), 64'(32'd2));
        chk("t2_no_ar", 64'(m_ar_valid), 64'(1'b0));
        send(32'd20, 16'h4500, 1'b0);
        c_c = acc_cyc;
        wait_until(c_c + 10);
        chk("t2_valid_early", 64'(m_ar_valid), 64'(1'b0));
        tick();
        chk("t2_valid", 64'(m_ar_valid), 64'(1'b1));
        chk("t2_addr", 64'(m_ar_addr), 64'(16'h4500));

        // Outstanding limit of 2, delta 0 entries, coincident AR/R
        do_reset();
        send(32'd0, 16'h0500, 1'b0);
        d1 = acc_cyc;
        send(32'd0, 16'h0600, 1'b0);
        d2 = acc_cyc;
        send(32'd0, 16'h0700, 1'b0);
        d3 = acc_cyc;
        chk("t3_period12", 64'(d2 - d1), 64'(3));
        chk("t3_period23", 64'(d3 - d2), 64'(3));
        chk("t3_stall_valid", 64'(m_ar_valid), 64'(1'b0));
        chk("t3_out_full", 64'(outstanding), 64'(2'd2));
        chk("t3_req2", 64'(st_reqCount), 64'(32'd2));
        wait_until(d3 + 6);
        chk("t3_still_stalled", 64'(m_ar_valid), 64'(1'b0));
        r_last_beat(1'b1);
        tick();
        // Third AR appears the cycle after the first R last; second R last now coincides with its handshake
        chk("t3_third_valid", 64'(m_ar_valid), 64'(1'b1));
        chk("t3_third_addr", 64'(m_ar_addr), 64'(16'h0700));
        chk("t3_latsum1", 64'(st_latSum), 64'(32'd10));
        tick();
        chk("t3_coinc_out", 64'(outstanding), 64'(2'd1));
        chk("t3_coinc_req", 64'(st_reqCount), 64'(32'd3));
        chk("t3_latsum2", 64'(st_latSum), 64'(32'd18));
        chk("t3_latmax2", 64'(st_latMax), 64'(32'd10));
        tick();
        r_last_beat(1'b0);
        chk("t3_latsum3", 64'(st_latSum), 64'(32'd19));
        chk("t3_resp3", 64'(st_respCount), 64'(32'd3));
        chk("t3_out0", 64'(outstanding), 64'(2'd0));

        // AR backpressure for 7 cycles with en and cfg toggling mid-ISSUE
        m_ar_ready = 1'b0;
        send(32'd4, 16'h1234, 1'b0);
        e_c = acc_cyc;
        wait_until(e_c + 2);
        chk("t4_valid_early", 64'(m_ar_valid), 64'(1'b0));
        tick();
        for (int i = 0; i < 7; i++) begin
            chk("t4_hold_valid", 64'(m_ar_valid), 64'(1'b1));
            chk("t4_hold_addr", 64'(m_ar_addr), 64'(16'h1234));
            chk("t4_hold_id", 64'(m_ar_id), 64'(8'h3C));
            chk("t4_hold_len", 64'(m_ar_len), 64'(8'h07));
            if (i == 1) en = 1'b0;
            if (i == 2) begin cfg_id = 8'h55; cfg_len = 8'h99; end
            if (i == 3) en = 1'b1;
            if (i == 4) begin cfg_id = 8'h3C; cfg_len = 8'h07; end
            tick();
        end
        m_ar_ready = 1'b1;
        chk("t4_valid_release", 64'(m_ar_valid), 64'(1'b1));
        tick();
        chk("t4_req", 64'(st_reqCount), 64'(32'd4));
        wait_until(e_c + 20);
        r_last_beat(1'b1);
        tick();
        r_last_beat(1'b0);
        chk("t4_latsum", 64'(st_latSum), 64'(32'd36));
        chk("t4_latmax", 64'(st_latMax), 64'(32'd17));

        // Reset in the middle of a long wait (W=(100-4)>>1=48)
        send(32'd100, 16'h2000, 1'b0);
        tick();
        tick();
        chk("t5_in_wait", 64'(m_ar_valid), 64'(1'b0));
        resetN = 1'b0;
        tick();
        chk("t5_t_ready", 64'(t_ready), 64'(1'b0));
        chk("t5_addr", 64'(m_ar_addr), 64'(16'h0000));
        chk("t5_req", 64'(st_reqCount), 64'(32'd0));
        chk("t5_resp", 64'(st_respCount), 64'(32'd0));
        chk("t5_latsum", 64'(st_latSum), 64'(32'd0));
        chk("t5_latmax", 64'(st_latMax), 64'(32'd0));
        chk("t5_out", 64'(outstanding), 64'(2'd0));
        resetN = 1'b1;
        tick();

        // Final entry drains to done; a stray last beat afterwards flags err
        send(32'd2, 16'h0800, 1'b1);
        f_c = acc_cyc;
        wait_until(f_c + 3);
        chk("t6_drain_out", 64'(outstanding), 64'(2'd1));
        chk("t6_drain_ready", 64'(t_ready), 64'(1'b0));
        chk("t6_not_done", 64'(done), 64'(1'b0));
        wait_until(f_c + 5);
        r_last_beat(1'b1);
        tick();
        r_last_beat(1'b0);
        tick();
        chk("t6_done", 64'(done), 64'(1'b1));
        chk("t6_latsum", 64'(st_latSum), 64'(32'd3));
        r_last_beat(1'b1);
        tick();
        r_last_beat(1'b0);
        chk("t7_err", 64'(err), 64'(1'b1));
        chk("t7_resp", 64'(st_respCount), 64'(32'd1));
        chk("t7_latsum", 64'(st_latSum), 64'(32'd3));
        chk("t7_out", 64'(outstanding), 64'(2'd0));
        chk("t7_done", 64'(done), 64'(1'b1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
